// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the in-order pipeline.
//
// Takes decoded operands from ID over a valid/ready handshake, produces either
// a single-cycle ALU result or runs a WIDTH-cycle shift-add multiply, and keeps
// the result in an output register until the MEM/WB side consumes it.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset
//   flush_i        kill in-flight work (branch redirect)
//   id_valid_i     ID presents an instruction
//   ex_ready_o     EX can accept this cycle (combinational)
//   id_op_i        operation code: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL
//                  7 SRA 8 SLT 9 SLTU 10 MUL, 11..15 illegal
//   id_opa_i       operand A
//   id_opb_i       operand B
//   id_imm_i       sign-extended immediate
//   id_use_imm_i   1 selects id_imm_i as operand B
//   id_rd_i        destination register
//   id_wb_en_i     instruction writes back
//   id_pc_i        instruction PC
//   ex_valid_o     output register holds a result
//   mem_ready_i    downstream consumes the result this cycle
//   ex_result_o    result
//   ex_rd_o        destination register
//   ex_wb_en_o     write-back enable
//   ex_pc_o        PC
//   ex_illegal_o   held instruction had an illegal opcode
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int SHAMT_W      = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  output logic                    ex_ready_o,
  input  logic [3:0]              id_op_i,
  input  logic [WIDTH-1:0]        id_opa_i,
  input  logic [WIDTH-1:0]        id_opb_i,
  input  logic [WIDTH-1:0]        id_imm_i,
  input  logic                    id_use_imm_i,
  input  logic [REG_ADDR_LEN-1:0] id_rd_i,
  input  logic                    id_wb_en_i,
  input  logic [WIDTH-3:0]        id_pc_i,
  output logic                    ex_valid_o,
  input  logic                    mem_ready_i,
  output logic [WIDTH-1:0]        ex_result_o,
  output logic [REG_ADDR_LEN-1:0] ex_rd_o,
  output logic                    ex_wb_en_o,
  output logic [WIDTH-3:0]        ex_pc_o,
  output logic                    ex_illegal_o
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e                  state_q;
  logic                    ex_valid_q;
  logic [WIDTH-1:0]        ex_result_q;
  logic [REG_ADDR_LEN-1:0] ex_rd_q;
  logic                    ex_wb_en_q;
  logic [WIDTH-3:0]        ex_pc_q;
  logic                    ex_illegal_q;
  logic [WIDTH-1:0]        mcand_q;
  logic [WIDTH-1:0]        mplier_q;
  logic [WIDTH-1:0]        acc_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [WIDTH-1:0]        opb_s;
  logic [SHAMT_W-1:0]      shamt_s;
  logic [WIDTH-1:0]        alu_s;
  logic [WIDTH-1:0]        acc_d;
  logic                    illegal_s;
  logic                    accept_s;

  // Ready only when idle and the output register is empty or draining now.
  assign ex_ready_o = !rst_i && (state_q == ST_IDLE) && (!ex_valid_q || mem_ready_i);
  assign accept_s   = id_valid_i && ex_ready_o && !flush_i;
  assign opb_s      = id_use_imm_i ? id_imm_i : id_opb_i;
  assign shamt_s    = opb_s[SHAMT_W-1:0];
  assign illegal_s  = (id_op_i > OP_MUL);
  // Accumulator value after this multiplier step.
  assign acc_d      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  assign ex_valid_o   = ex_valid_q;
  assign ex_result_o  = ex_result_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_wb_en_o   = ex_wb_en_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_illegal_o = ex_illegal_q;

  // Single-cycle ALU result for the instruction currently on the ID inputs.
  always_comb begin
    alu_s = '0;
    case (id_op_i)
      OP_ADD:  alu_s = id_opa_i + opb_s;
      OP_SUB:  alu_s = id_opa_i - opb_s;
      OP_AND:  alu_s = id_opa_i & opb_s;
      OP_OR:   alu_s = id_opa_i | opb_s;
      OP_XOR:  alu_s = id_opa_i ^ opb_s;
      OP_SLL:  alu_s = id_opa_i << shamt_s;
      OP_SRL:  alu_s = id_opa_i >> shamt_s;
      OP_SRA:  alu_s = $signed(id_opa_i) >>> shamt_s;
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(id_opa_i) < $signed(opb_s))};
      OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (id_opa_i < opb_s)};
      // MUL is produced by the iterative path; illegal opcodes read as zero.
      default: alu_s = '0;
    endcase
  end

  // Control FSM, output register and shift-add multiplier datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ex_valid_q   <= 1'b0;
      ex_result_q  <= '0;
      ex_rd_q      <= '0;
      ex_wb_en_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_illegal_q <= 1'b0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else if (flush_i) begin
      // Flush wins over both accept and multiply completion.
      state_q      <= ST_IDLE;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // Drain; overridden below when a new result lands on the same edge.
      if (ex_valid_q && mem_ready_i) begin
        ex_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            ex_rd_q <= id_rd_i;
            ex_pc_q <= id_pc_i;
            if (id_op_i == OP_MUL) begin
              // Output register is empty for the whole multiply.
              ex_wb_en_q   <= id_wb_en_i;
              ex_illegal_q <= 1'b0;
              mcand_q      <= id_opa_i;
              mplier_q     <= opb_s;
              acc_q        <= '0;
              cnt_q        <= CNT_W'(WIDTH - 1);
              state_q      <= ST_MUL;
            end else begin
              ex_result_q  <= alu_s;
              ex_wb_en_q   <= id_wb_en_i && !illegal_s;
              ex_illegal_q <= illegal_s;
              ex_valid_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1'b1;
          mplier_q <= mplier_q >> 1'b1;
          if (cnt_q == '0) begin
            ex_result_q <= acc_d;
            ex_valid_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// A vector table (directed + random) is issued through the handshake; each
// accepted instruction pushes its expected output record onto a scoreboard
// that a monitor pops whenever the DUT hands a result downstream. Hand-written
// sequences cover multiply latency, downstream stall, flush and reset.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    logic [29:0] pc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        use_imm;
    logic        wb;
    logic [31:0] exp;
  } vec_t;

  localparam int N_FIXED = 15;
  localparam int N_RAND  = 12;
  localparam int N_VEC   = N_FIXED + N_RAND;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        ex_ready;
  logic [3:0]  id_op;
  logic [31:0] id_opa;
  logic [31:0] id_opb;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [4:0]  id_rd;
  logic        id_wb_en;
  logic [29:0] id_pc;
  logic        ex_valid;
  logic        mem_ready;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_wb_en;
  logic [29:0] ex_pc;
  logic        ex_illegal;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t tbl[N_VEC];

  ex_stage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .id_valid_i   (id_valid),
    .ex_ready_o   (ex_ready),
    .id_op_i      (id_op),
    .id_opa_i     (id_opa),
    .id_opb_i     (id_opb),
    .id_imm_i     (id_imm),
    .id_use_imm_i (id_use_imm),
    .id_rd_i      (id_rd),
    .id_wb_en_i   (id_wb_en),
    .id_pc_i      (id_pc),
    .ex_valid_o   (ex_valid),
    .mem_ready_i  (mem_ready),
    .ex_result_o  (ex_result),
    .ex_rd_o      (ex_rd),
    .ex_wb_en_o   (ex_wb_en),
    .ex_pc_o      (ex_pc),
    .ex_illegal_o (ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model, written independently of the DUT's operator choices.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a + (~b) + 32'd1;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:    r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:    r = (a < b) ? 32'd1 : 32'd0;
      4'd10:   r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Monitor: compare each result as it is consumed downstream.
  always @(negedge clk) begin
    if (!rst && ex_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h expected=none @%0t", ex_result, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result",  ex_result, e.res);
        chk("rd",      {27'd0, ex_rd}, {27'd0, e.rd});
        chk("wb_en",   {31'd0, ex_wb_en}, {31'd0, e.wb});
        chk("pc",      {2'd0, ex_pc}, {2'd0, e.pc});
        chk("illegal", {31'd0, ex_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Drive one instruction and hold it until accepted (bounded wait).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                       input logic wb, input logic [29:0] pc, input logic push,
                       input logic [31:0] exp_res);
    bit done;
    done       = 1'b0;
    id_op      = op;
    id_opa     = a;
    id_opb     = b;
    id_imm     = imm;
    id_use_imm = use_imm;
    id_rd      = rd;
    id_wb_en   = wb;
    id_pc      = pc;
    id_valid   = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (ex_ready && !flush) begin
        done = 1'b1;
        if (push) begin
          sb_q.push_back('{res: exp_res, rd: rd, wb: wb && (op < 4'd11), pc: pc, ill: (op >= 4'd11)});
        end
      end
      @(posedge clk);
      #1;
    end
    id_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 expected=1 op=%0d", op);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    rst        = 1'b1;
    flush      = 1'b0;
    id_valid   = 1'b0;
    id_op      = 4'd0;
    id_opa     = 32'd0;
    id_opb     = 32'd0;
    id_imm     = 32'd0;
    id_use_imm = 1'b0;
    id_rd      = 5'd0;
    id_wb_en   = 1'b0;
    id_pc      = 30'd0;
    mem_ready  = 1'b1;

    // Vector table: directed cases followed by random ones.
    tbl[0]  = '{4'd0,  32'd5,          32'd7,          32'd0, 1'b0, 1'b1, 32'd12};
    tbl[1]  = '{4'd1,  32'd0,          32'd1,          32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tbl[2]  = '{4'd7,  32'h8000_0000,  32'h1234_5678,  32'd4, 1'b1, 1'b1, 32'hF800_0000};
    tbl[3]  = '{4'd8,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0, 1'b1, 32'd1};
    tbl[4]  = '{4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{4'd2,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 1'b0, 1'b1, 32'hF000_F000};
    tbl[6]  = '{4'd3,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 1'b0, 1'b1, 32'hFFF0_FFF0};
    tbl[7]  = '{4'd4,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 1'b0, 1'b1, 32'h0FF0_0FF0};
    tbl[8]  = '{4'd5,  32'd1,          32'd31,         32'd0, 1'b0, 1'b1, 32'h8000_0000};
    tbl[9]  = '{4'd6,  32'h8000_0000,  32'd31,         32'd0, 1'b0, 1'b1, 32'd1};
    tbl[10] = '{4'd5,  32'd3,          32'h0000_0021,  32'd0, 1'b0, 1'b1, 32'd6};
    tbl[11] = '{4'd10, 32'h0000_FFFF,  32'h0001_0001,  32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tbl[12] = '{4'd12, 32'd9,          32'd9,          32'd0, 1'b0, 1'b1, 32'd0};
    tbl[13] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd0, 1'b0, 1'b1, 32'd1};
    tbl[14] = '{4'd8,  32'd1,          32'hFFFF_FFFF,  32'd0, 1'b0, 1'b1, 32'd0};
    for (int i = N_FIXED; i < N_VEC; i++) begin
      tbl[i].op      = 4'($urandom_range(0, 10));
      tbl[i].a       = $urandom;
      tbl[i].b       = $urandom;
      tbl[i].imm     = $urandom;
      tbl[i].use_imm = 1'($urandom_range(0, 1));
      tbl[i].wb      = 1'b1;
      tbl[i].exp     = model(tbl[i].op, tbl[i].a, tbl[i].use_imm ? tbl[i].imm : tbl[i].b);
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", {31'd0, ex_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid",   {31'd0, ex_valid}, 32'd0);
    chk("rst_result",  ex_result, 32'd0);
    chk("rst_rd",      {27'd0, ex_rd}, 32'd0);
    chk("rst_wb_en",   {31'd0, ex_wb_en}, 32'd0);
    chk("rst_pc",      {2'd0, ex_pc}, 32'd0);
    chk("rst_illegal", {31'd0, ex_illegal}, 32'd0);
    chk("rst_ready",   {31'd0, ex_ready}, 32'd1);
    @(posedge clk);
    #1;

    // ADD latency: valid right after the accept edge, ready stays high.
    issue(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 30'h123, 1'b1, 32'd12);
    chk("add_valid_lat1", {31'd0, ex_valid}, 32'd1);
    chk("add_ready_held", {31'd0, ex_ready}, 32'd1);

    // Table of vectors, back to back.
    for (int i = 0; i < N_VEC; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].use_imm, 5'(i + 1),
            tbl[i].wb, 30'(i * 4 + 64), 1'b1, tbl[i].exp);
    end

    // MUL latency: ready low throughout, valid exactly WIDTH cycles after accept.
    issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b0, 5'd17, 1'b1, 30'h2AA, 1'b1, 32'hFFFF_FFFF);
    n    = 0;
    seen = 1'b0;
    while (!ex_valid && n < 40) begin
      if (ex_ready) seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", n, 32'd32);
    chk("mul_ready_low", {31'd0, seen}, 32'd0);

    // Downstream stall with a second instruction waiting.
    issue(4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 5'd7, 1'b1, 30'h100, 1'b1, 32'd42);
    mem_ready = 1'b0;
    // The ADD result is held; the edge in issue() already loaded it.
    id_op    = 4'd1;
    id_opa   = 32'd100;
    id_opb   = 32'd1;
    id_rd    = 5'd9;
    id_pc    = 30'h200;
    id_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready",  {31'd0, ex_ready}, 32'd0);
      chk("stall_valid",  {31'd0, ex_valid}, 32'd1);
      chk("stall_result", ex_result, 32'd42);
      chk("stall_rd",     {27'd0, ex_rd}, 32'd7);
      chk("stall_pc",     {2'd0, ex_pc}, 32'h100);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    issue(4'd1, 32'd100, 32'd1, 32'd0, 1'b0, 5'd9, 1'b1, 30'h200, 1'b1, 32'd99);

    // Flush at multiply cycle 10: no result ever appears.
    issue(4'd10, 32'd1234, 32'd5678, 32'd0, 1'b0, 5'd11, 1'b1, 30'h300, 1'b0, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_ready", {31'd0, ex_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ex_valid) seen = 1'b1;
    end
    chk("flush_no_result", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #1;
    issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1, 30'h10, 1'b1, 32'd2);
    issue(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 5'd2, 1'b1, 30'h14, 1'b1, 32'd4);
    issue(4'd0, 32'd3, 32'd3, 32'd0, 1'b0, 5'd3, 1'b1, 30'h18, 1'b1, 32'd6);

    // Reset mid-multiply: everything back to zero, no partial result.
    issue(4'd10, 32'd77, 32'd88, 32'd0, 1'b0, 5'd21, 1'b1, 30'h3FF, 1'b0, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmul_valid",   {31'd0, ex_valid}, 32'd0);
    chk("rstmul_result",  ex_result, 32'd0);
    chk("rstmul_rd",      {27'd0, ex_rd}, 32'd0);
    chk("rstmul_wb_en",   {31'd0, ex_wb_en}, 32'd0);
    chk("rstmul_pc",      {2'd0, ex_pc}, 32'd0);
    chk("rstmul_illegal", {31'd0, ex_illegal}, 32'd0);
    chk("rstmul_ready",   {31'd0, ex_ready}, 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ex_valid) seen = 1'b1;
    end
    chk("rstmul_no_result", {31'd0, seen}, 32'd0);

    // Every expected result must have been consumed.
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
